// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the 2048 x 16 SRAM controller.
package sram_pkg;

  localparam int SRAM_AW = 11;
  localparam int BUS_W   = 32;
  localparam int HALF_W  = 16;

  // One state per SRAM bus phase; a word access walks a path twice (half 0, half 1).
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_R_ADDR   = 3'd1,
    S_R_LOAD   = 3'd2,
    S_R_SAMPLE = 3'd3,
    S_W_ADDR   = 3'd4,
    S_W_LOAD   = 3'd5,
    S_W_COMMIT = 3'd6,
    S_DONE     = 3'd7
  } state_e;

endpackage

// File: rtl/sram_bus_tri.sv
// Tristate driver for the shared SRAM data bus; din always reflects the bus.
module sram_bus_tri #(
  parameter int BUS_W = 32
) (
  input  logic             drv,
  input  logic [BUS_W-1:0] dout,
  inout  wire  [BUS_W-1:0] data,
  output logic [BUS_W-1:0] din
);

  assign data = drv ? dout : {BUS_W{1'bz}};
  assign din  = data;

endmodule

// File: rtl/sram_ctrl.sv
// Upstream master for the 2048 x 16 SRAM: splits 32-bit word accesses into
// two 16-bit accesses (low half at even address, high half at odd) and
// sequences adrx / nOE / read. A rising edge on read commits an SRAM write,
// so read only drops inside a write sequence.
// Optional: SRAM_CTRL_HALF_EN adds size/hsel ports for single 16-bit accesses.
module sram_ctrl #(
  parameter int SRAM_AW = 11,
  parameter int BUS_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               we,
  input  logic [SRAM_AW-2:0] addr,
  input  logic [BUS_W-1:0]   wdata,
`ifdef SRAM_CTRL_HALF_EN
  input  logic               size,
  input  logic               hsel,
`endif
  output logic               ready,
  output logic               done,
  output logic [BUS_W-1:0]   rdata,
  output logic [SRAM_AW-1:0] adrx,
  output logic               nOE,
  output logic               read,
  inout  wire  [BUS_W-1:0]   data
);
  import sram_pkg::*;

  state_e             state_q, state_d;
  logic               half_q, half_d;
  logic [SRAM_AW-2:0] addr_q, addr_d;
  logic [BUS_W-1:0]   wdata_q, wdata_d;
  logic [BUS_W-1:0]   rdata_q, rdata_d;
  logic [SRAM_AW-1:0] adrx_q, adrx_d;
  logic               noe_q, noe_d;
  logic               read_q, read_d;
  logic               drv_q, drv_d;
  logic               done_q, done_d;
`ifdef SRAM_CTRL_HALF_EN
  logic               size_q, size_d;
`endif

  logic               last;
  logic [HALF_W-1:0]  wr_half;
  logic [BUS_W-1:0]   dout;
  logic [BUS_W-1:0]   din;

  // The current pass is the final one: high half of a word, or a single half access.
`ifdef SRAM_CTRL_HALF_EN
  assign last = half_q | size_q;
`else
  assign last = half_q;
`endif

  // Half of the latched write word placed on the bus during the write passes.
  always_comb begin
    wr_half = half_q ? wdata_q[2*HALF_W-1:HALF_W] : wdata_q[HALF_W-1:0];
`ifdef SRAM_CTRL_HALF_EN
    if (size_q) wr_half = wdata_q[HALF_W-1:0];
`endif
  end

  assign dout = {{(BUS_W-HALF_W){1'b0}}, wr_half};

  sram_bus_tri #(.BUS_W(BUS_W)) u_bus (
    .drv  (drv_q),
    .dout (dout),
    .data (data),
    .din  (din)
  );

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign rdata = rdata_q;
  assign adrx  = adrx_q;
  assign nOE   = noe_q;
  assign read  = read_q;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      half_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      adrx_q  <= '0;
      noe_q   <= 1'b1;
      read_q  <= 1'b1;
      drv_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SRAM_CTRL_HALF_EN
      size_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      adrx_q  <= adrx_d;
      noe_q   <= noe_d;
      read_q  <= read_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
`ifdef SRAM_CTRL_HALF_EN
      size_q  <= size_d;
`endif
    end
  end

  // Next-state: request latch, half sequencing and read-data capture.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_CTRL_HALF_EN
    size_d  = size_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          half_d  = 1'b0;
`ifdef SRAM_CTRL_HALF_EN
          size_d  = size;
          if (size) half_d = hsel;
`endif
          state_d = we ? S_W_ADDR : S_R_ADDR;
        end
      end
      S_R_ADDR: state_d = S_R_LOAD;
      S_R_LOAD: state_d = S_R_SAMPLE;
      S_R_SAMPLE: begin
`ifdef SRAM_CTRL_HALF_EN
        if (size_q) rdata_d = {{(BUS_W-HALF_W){1'b0}}, din[HALF_W-1:0]};
        else
`endif
        if (half_q) rdata_d[2*HALF_W-1:HALF_W] = din[HALF_W-1:0];
        else        rdata_d[HALF_W-1:0]        = din[HALF_W-1:0];
        if (last) state_d = S_DONE;
        else begin
          half_d  = 1'b1;
          state_d = S_R_ADDR;
        end
      end
      S_W_ADDR: state_d = S_W_LOAD;
      S_W_LOAD: state_d = S_W_COMMIT;
      S_W_COMMIT: begin
        if (last) state_d = S_DONE;
        else begin
          half_d  = 1'b1;
          state_d = S_W_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state.
  always_comb begin
    adrx_d = adrx_q;
    noe_d  = 1'b1;
    read_d = 1'b1;
    drv_d  = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_R_ADDR, S_R_LOAD: adrx_d = {addr_d, half_d};
      S_R_SAMPLE: begin
        adrx_d = {addr_d, half_d};
        noe_d  = 1'b0;
      end
      S_W_ADDR, S_W_LOAD: begin
        adrx_d = {addr_d, half_d};
        read_d = 1'b0;
        drv_d  = 1'b1;
      end
      S_W_COMMIT: begin
        adrx_d = {addr_d, half_d};
        drv_d  = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural 2048 x 16 SRAM on the bus.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, nOE, read;
  logic [31:0] rdata;
  logic [10:0] adrx;
  wire  [31:0] data;
`ifdef SRAM_CTRL_HALF_EN
  logic        size = 1'b0;
  logic        hsel = 1'b0;
`endif

  always #5 clk = ~clk;

  sram_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef SRAM_CTRL_HALF_EN
    .size(size), .hsel(hsel),
`endif
    .ready(ready), .done(done), .rdata(rdata), .adrx(adrx),
    .nOE(nOE), .read(read), .data(data)
  );

  // Behavioural SRAM: data register loads from the array while read is high,
  // captures the bus while read is low, a rising read commits, nOE drives it out.
  logic [15:0] mem [2048];
  logic [15:0] dreg = '0;
  assign data = !nOE ? {16'h0, dreg} : 32'hzzzz_zzzz;
  always @(posedge clk) begin
    if (!read) dreg <= data[15:0];
    else       dreg <= mem[adrx];
  end
  always @(posedge read) mem[adrx] <= dreg;

  // Reference model: word-addressed memory.
  logic [31:0] ref_mem [1024];

  typedef struct {
    bit          rd;
    logic [31:0] exp;
    int          acc;
    int          rise0;
    int          nlow0;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, rises = 0, nlow = 0, acc_cnt = 0;
  int acc_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  always @(posedge read) if (!rst) rises++;

  // Accept detection: push the expected response from the reference model.
  always @(posedge clk) begin
    if (!rst && req && ready) begin
      exp_t e;
      e.rd    = !we;
      e.exp   = ref_mem[addr];
      e.acc   = cyc;
      e.rise0 = rises;
      e.nlow0 = nlow;
      if (we) ref_mem[addr] = wdata;
      sbq.push_back(e);
      acc_cyc.push_back(cyc);
      acc_cnt++;
    end
    cyc = cyc + 1;
  end

  // Monitor: per-cycle bus rule, and scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (!nOE) nlow++;
      check("bus_contention", {31'b0, dut.drv_q & ~nOE}, 32'h0);
      if (done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("done_latency", cyc - e.acc, 32'd7);
          check("read_rises", rises - e.rise0, e.rd ? 32'd0 : 32'd2);
          check("noe_low_cycles", nlow - e.nlow0, e.rd ? 32'd2 : 32'd0);
          if (e.rd) check("rdata", rdata, e.exp);
        end
      end
    end
  end

  // Issue one request and drop req once it is accepted.
  task automatic issue(input bit w, input logic [9:0] a, input logic [31:0] d);
    int prev;
    bit ok;
    prev = acc_cnt;
    ok = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (acc_cnt != prev) ok = 1'b1;
    end
    req = 1'b0;
    if (!ok) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) check("drain_timeout", sbq.size(), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

    // Reset held 3 cycles.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_read",  read,  1);
    check("rst_noe",   nOE,   1);
    check("rst_done",  done,  0);
    check("rst_drv",   dut.drv_q, 0);
    check("rst_rdata", rdata, 0);
    check("rst_adrx",  adrx,  0);
    repeat (3) @(negedge clk);
    check("idle_no_read_rise", rises, 0);

    // Directed write/read at 0x005.
    issue(1'b1, 10'h005, 32'hDEAD_BEEF);
    drain();
    check("mem_00a", mem[11'h00A], 16'hBEEF);
    check("mem_00b", mem[11'h00B], 16'hDEAD);
    issue(1'b0, 10'h005, 32'h0);
    drain();
    check("rd_005_hold", rdata, 32'hDEAD_BEEF);

    // Top of address range.
    issue(1'b1, 10'h3FF, 32'h1234_5678);
    drain();
    check("mem_7fe", mem[11'h7FE], 16'h5678);
    check("mem_7ff", mem[11'h7FF], 16'h1234);
    issue(1'b0, 10'h3FF, 32'h0);
    drain();

    // req held high across 4 alternating write/read requests.
    acc_cyc.delete();
    @(negedge clk);
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int prev;
      bit ok;
      prev = acc_cnt;
      ok = 1'b0;
      we = (i % 2 == 0);
      addr = 10'h010 + 10'(i / 2);
      wdata = $urandom;
      for (int j = 0; j < 40 && !ok; j++) begin
        @(negedge clk);
        if (acc_cnt != prev) ok = 1'b1;
      end
      if (!ok) check("b2b_accept_timeout", 32'h0, 32'h1);
      // Change inputs while busy; these must be ignored.
      we = ~we;
      addr = addr + 10'd7;
    end
    req = 1'b0;
    drain();
    check("b2b_accept_count", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 8);

    // Randomized traffic over a small address pool so reads hit prior writes.
    for (int i = 0; i < 40; i++) begin
      logic [9:0] a;
      a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();

    // Reset during the high-half sample of a read.
    begin
      int lows;
      bit hit;
      lows = 0;
      hit = 1'b0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 10'h005;
      for (int i = 0; i < 40 && !hit; i++) begin
        @(negedge clk);
        req = 1'b0;
        if (!nOE) lows++;
        if (lows == 2) hit = 1'b1;
      end
      if (!hit) check("mid_rst_reach_sample", 32'h0, 32'h1);
      rst = 1'b1;
      sbq.delete();
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_ready", ready, 1);
      check("mid_rst_noe",   nOE,   1);
      check("mid_rst_done",  done,  0);
      check("mid_rst_read",  read,  1);
      repeat (8) @(negedge clk);
      check("mid_rst_no_pending", sbq.size(), 0);
    end
    issue(1'b0, 10'h005, 32'h0);
    drain();
    check("post_rst_rdata", rdata, ref_mem[10'h005]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Upstream master for the 2048 x 16 SRAM array stage.
- Accepts 32-bit word read/write requests from the CPU side and splits each word into two 16-bit SRAM accesses: low half at even SRAM address, high half at odd.
- Sequences adrx, nOE and read, and owns the shared 32-bit tristate data bus whenever the SRAM is not driving it.

Parameters:
- SRAM_AW, 11, SRAM address width; word address width is SRAM_AW-1.
- BUS_W, 32, width of the shared data bus and the CPU data ports.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  request valid; accepted when req & ready.
- we  in  1  1 = write, 0 = read; sampled on accept.
- addr  in  SRAM_AW-1  word address; sampled on accept.
- wdata  in  BUS_W  write word; sampled on accept.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  BUS_W  read result; valid while done=1, held until the next read completes.
- adrx  out  SRAM_AW  SRAM address, registered.
- nOE  out  1  SRAM output enable, active-low, registered.
- read  out  1  SRAM read/commit strobe, registered; idles high.
- data  inout  BUS_W  shared bus; driven only when drv=1, else high-Z.

Behaviour:
- Reset: state=IDLE, ready=1, done=0, rdata=0, adrx=0, nOE=1, read=1, drv=0, internal latches cleared.
- read idles high. A rising edge of read is the SRAM write commit, so read falls only inside a write sequence. A read never generates a rising edge.
- Bus rule: drv and ~nOE are never both 1. nOE=0 only in R_SAMPLE. drv=1 only in W_ADDR, W_LOAD and W_COMMIT.
- When driving, data = {16'b0, current half of the latched wdata}.
- States: IDLE, R_ADDR, R_LOAD, R_SAMPLE, W_ADDR, W_LOAD, W_COMMIT, DONE. A half flag (0 = low, 1 = high) is cleared on accept.
- IDLE:
  - On req & ready, latch addr, we and wdata.
  - Go to W_ADDR if we=1, else R_ADDR.
  - req while not ready is ignored; it is not queued.
- Read path:
  - R_ADDR: adrx={addr,half}, read=1, nOE=1.
  - R_LOAD: hold, so the SRAM registers the address and loads its data register.
  - R_SAMPLE: nOE=0. At the exit edge, capture data[15:0] into rdata[15:0] (half=0) or rdata[31:16] (half=1).
  - Exit from R_SAMPLE: nOE=1; go to R_ADDR with half=1, or to DONE if half was 1.
- Write path:
  - W_ADDR: adrx={addr,half}, read=0, nOE=1, drv=1.
  - W_LOAD: hold, so the SRAM data register captures the bus.
  - W_COMMIT: read=1 (rising edge commits), drv stays 1.
  - Exit from W_COMMIT: go to W_ADDR with half=1, or to DONE.
- DONE: done=1, ready=0, drv=0, read=1, nOE=1; go to IDLE.
- Latency, word access: accept edge at cycle k; DONE occupies cycle k+7; ready returns at k+8.
- Back-to-back: req held high continuously yields one accept every 8 cycles.
- Address wrap: addr is SRAM_AW-1 bits, so {addr,1} never overflows; no wrap logic is required.
- Reset mid-operation:
  - Immediate return to reset values; no done pulse.
  - Reset during W_ADDR/W_LOAD raises read and may commit a partial half. Contents at that SRAM address are then undefined; all other addresses are unaffected.

Optional Feature:
- Macro: SRAM_CTRL_HALF_EN.
- Defined:
  - Adds input size (1 bit, 0 = word, 1 = half) and input hsel (1 bit), both sampled on accept.
  - size=1 performs a single pass at {addr,hsel}.
  - Half write drives wdata[15:0].
  - Half read returns {16'b0, data} in rdata.
  - Latency is accept k -> done k+4.
- Undefined: ports absent; every access is a full word.

Decomposition:
- Shared package sram_pkg: state encoding constants, HALF_W=16, BUS_W, SRAM_AW.
- One sub-module, sram_bus_tri: BUS_W-wide tristate driver (inputs drv and dout, inout data, output din).

Test Plan:
- Reset hold 3 cycles, then release -> ready=1, read=1, nOE=1, data high-Z, done=0; no rising edge on read.
- Write 0xDEADBEEF to addr 0x005 -> adrx 0x00A then 0x00B; read pulses low-high twice; done at accept+7; SRAM[0x00A]=0xBEEF, SRAM[0x00B]=0xDEAD.
- Read addr 0x005 after the write -> rdata=0xDEADBEEF with done at accept+7; read stays high throughout; nOE low exactly 2 cycles.
- Write 0x12345678 to addr 0x3FF, then read 0x3FF -> adrx 0x7FE/0x7FF and read returns 0x12345678. Checker asserts drv & ~nOE never true on any cycle.
- req held high with 4 alternating write/read requests -> accepts spaced exactly 8 cycles; requests during busy are ignored; each done is a single cycle.
- Reset asserted in R_SAMPLE of the high half -> next cycle IDLE, nOE=1, no done; a subsequent read of the same address returns the correct word.
